// File: rtl/crc_stream_check_if.sv
// rtl/crc_stream_check_if.sv - stream handshake bundle between packet buffer, CRC checker and downstream
interface crc_stream_check_if #(
  parameter int DW = 32
);
  logic            iRdSop;
  logic            iRdEop;
  logic            iRdVld;
  logic            iRdLast;
  logic [DW/8-1:0] iRdKeep;
  logic [DW-1:0]   iRdData;
  logic            oRdReady;
  logic            oRdSop;
  logic            oRdEop;
  logic            oRdVld;
  logic            oRdLast;
  logic [DW/8-1:0] oRdKeep;
  logic [DW-1:0]   oRdData;
  logic            iReady;

  modport master (
    output iRdSop, iRdEop, iRdVld, iRdLast, iRdKeep, iRdData, iReady,
    input  oRdReady, oRdSop, oRdEop, oRdVld, oRdLast, oRdKeep, oRdData
  );

  modport slave (
    input  iRdSop, iRdEop, iRdVld, iRdLast, iRdKeep, iRdData, iReady,
    output oRdReady, oRdSop, oRdEop, oRdVld, oRdLast, oRdKeep, oRdData
  );
endinterface

// File: rtl/crc_stream_check.sv
// rtl/crc_stream_check.sv - parametrised packet-stream CRC checker with one-stage forwarding register
// Status for a packet is reported on a single oRdEop cycle that always trails its last output beat.
module crc_stream_check #(
  parameter int               DW        = 32,
  parameter int               CRC_W     = 16,
  parameter logic [CRC_W-1:0] POLY      = 16'h1021,
  parameter logic [CRC_W-1:0] INIT      = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOROUT    = 16'h0000,
  parameter bit               STRIP_CRC = 1'b1,
  parameter int               CNT_W     = 16
) (
  input  logic              iClk,
  input  logic              iRst_n,
  crc_stream_check_if.slave rd,
  output logic              oErr,
  output logic [1:0]        oErrCode,
  output logic [CNT_W-1:0]  oPktCnt,
  output logic [CNT_W-1:0]  oErrCnt
);
  localparam int KW = DW / 8;
  localparam int SW = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, DATA, WAIT_EOP} state_e;

  state_e             state_q;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic               crc_bad_q, frame_q;
  logic               out_vld_q, out_last_q;
  logic [DW-1:0]      out_data_q;
  logic [KW-1:0]      out_keep_q;
  logic               sop_q, eop_q, err_q;
  logic [1:0]         code_q;
  logic               eop_pend_q;
  logic [1:0]         pend_code_q;
  logic [CNT_W-1:0]   pkt_cnt_q, err_cnt_q;

  logic               accept, beat_data, beat_crc, load, out_vld_d;
  logic               close, frame_d, bad_d, orphan;
  logic               fire_now, fire_pend, fire;
  logic [1:0]         close_code, fire_code;
  logic [SW-1:0]      err_sum;

  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] b);
    logic [CRC_W-1:0] r;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      if (r[CRC_W-1] ^ b[k]) r = (r << 1) ^ POLY;
      else                   r = r << 1;
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < KW; i++) begin
      if (rd.iRdKeep[i]) crc_d = crc_byte(crc_d, rd.iRdData[8*i +: 8]);
    end
  end

  assign accept    = rd.iRdVld && rd.oRdReady;
  assign beat_data = accept && (state_q == DATA) && !rd.iRdLast;
  assign beat_crc  = accept && (state_q == DATA) && rd.iRdLast;
  assign load      = beat_data || (beat_crc && !STRIP_CRC);
  assign out_vld_d = load || (out_vld_q && !rd.iReady);
  assign orphan    = accept && (state_q == IDLE);

  assign close   = rd.iRdEop && (state_q == DATA || state_q == WAIT_EOP);
  assign frame_d = frame_q
                || (rd.iRdSop && state_q != IDLE)
                || (rd.iRdEop && state_q == DATA)
                || (accept && state_q == WAIT_EOP);
  assign bad_d      = crc_bad_q || (beat_crc && (rd.iRdData[CRC_W-1:0] != (crc_q ^ XOROUT)));
  assign close_code = {frame_d, bad_d};

  // A close that would overtake a beat still parked in the output register waits for it to leave.
  assign fire_now  = close && !out_vld_d;
  assign fire_pend = eop_pend_q && out_vld_q && rd.iReady;
  assign fire      = fire_now || fire_pend;
  assign fire_code = fire_now ? close_code : pend_code_q;
  assign err_sum   = {1'b0, err_cnt_q} + SW'(orphan) + SW'(fire && (|fire_code));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      crc_bad_q   <= 1'b0;
      frame_q     <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'b00;
      eop_pend_q  <= 1'b0;
      pend_code_q <= 2'b00;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      if (load) begin
        out_data_q <= rd.iRdData;
        out_keep_q <= rd.iRdKeep;
        out_last_q <= beat_crc;
      end
      sop_q  <= rd.iRdSop && (state_q == IDLE);
      eop_q  <= fire;
      err_q  <= fire && (|fire_code);
      code_q <= fire ? fire_code : 2'b00;
      if (close && out_vld_d) begin
        eop_pend_q  <= 1'b1;
        pend_code_q <= close_code;
      end else if (fire_pend) begin
        eop_pend_q <= 1'b0;
      end
      if (fire && (pkt_cnt_q != {CNT_W{1'b1}})) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      err_cnt_q <= err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
      case (state_q)
        IDLE: begin
          if (rd.iRdSop) begin
            state_q   <= DATA;
            crc_q     <= INIT;
            crc_bad_q <= 1'b0;
            frame_q   <= 1'b0;
          end
        end
        DATA: begin
          if (beat_data) crc_q <= crc_d;
          crc_bad_q <= bad_d;
          frame_q   <= frame_d;
          if (rd.iRdEop)     state_q <= IDLE;
          else if (beat_crc) state_q <= WAIT_EOP;
        end
        WAIT_EOP: begin
          frame_q <= frame_d;
          if (rd.iRdEop) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd.oRdReady = !out_vld_q || rd.iReady;
  assign rd.oRdVld   = out_vld_q;
  assign rd.oRdData  = out_data_q;
  assign rd.oRdKeep  = out_keep_q;
  assign rd.oRdLast  = out_last_q;
  assign rd.oRdSop   = sop_q;
  assign rd.oRdEop   = eop_q;
  assign oErr        = err_q;
  assign oErrCode    = code_q;
  assign oPktCnt     = pkt_cnt_q;
  assign oErrCnt     = err_cnt_q;
endmodule

// File: tb/tb_crc_stream_check.sv
// tb/tb_crc_stream_check.sv - self-checking bench for crc_stream_check (CRC-16/32-bit and CRC-32/64-bit instances)
module tb_crc_stream_check;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crc_stream_check_if #(.DW(32)) if16();
  crc_stream_check_if #(.DW(64)) if32();

  logic        err16, err32;
  logic [1:0]  code16, code32;
  logic [15:0] pkt16, errc16, pkt32, errc32;

  crc_stream_check #(.DW(32)) dut16 (
    .iClk(clk), .iRst_n(rst_n), .rd(if16),
    .oErr(err16), .oErrCode(code16), .oPktCnt(pkt16), .oErrCnt(errc16)
  );

  crc_stream_check #(
    .DW(64), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .XOROUT(32'hFFFFFFFF), .STRIP_CRC(1'b0)
  ) dut32 (
    .iClk(clk), .iRst_n(rst_n), .rd(if32),
    .oErr(err32), .oErrCode(code32), .oPktCnt(pkt32), .oErrCnt(errc32)
  );

  typedef struct {
    string      name;
    int         nbytes;
    bit         bad;
    bit         no_crc;
    bit         extra_sop;
    bit         bp;
    logic [1:0] exp_code;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_pkt = 0;
  int exp_err = 0;
  bit bp_en = 0;
  bit garbage = 0;
  logic [7:0]  pkt_bytes[$];
  logic [35:0] exp_beats[$];

  // Monitors: only these blocks append to the observation queues.
  logic [35:0] got16[$];
  logic [1:0]  ecode16[$];
  logic        eerr16[$];
  int          enb16[$];
  logic [15:0] epkt16[$];
  logic [15:0] eerrc16[$];
  int          sop16 = 0;
  logic [72:0] got32[$];
  logic [1:0]  ecode32[$];
  logic        eerr32[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (if16.oRdVld && if16.iReady) got16.push_back({if16.oRdKeep, if16.oRdData});
      if (if16.oRdSop) sop16++;
      if (if16.oRdEop) begin
        ecode16.push_back(code16);
        eerr16.push_back(err16);
        enb16.push_back(got16.size());
        epkt16.push_back(pkt16);
        eerrc16.push_back(errc16);
      end
      if (if32.oRdVld && if32.iReady) got32.push_back({if32.oRdLast, if32.oRdKeep, if32.oRdData});
      if (if32.oRdEop) begin
        ecode32.push_back(code32);
        eerr32.push_back(err32);
      end
    end
  end

  initial begin
    if16.iReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if16.iReady = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Non-reflected CRC of pkt_bytes, message bits taken MSB-first from each byte in order.
  function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input logic [31:0] xorout);
    logic [31:0] r, mask;
    logic        top;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    r = init & mask;
    foreach (pkt_bytes[i]) begin
      for (int b = 7; b >= 0; b--) begin
        top = r[w-1] ^ pkt_bytes[i][b];
        r = (r << 1) & mask;
        if (top) r = r ^ poly;
      end
    end
    return (r ^ xorout) & mask;
  endfunction

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, ".vld"},   if16.oRdVld, 0);
    chk({tag, ".sop"},   if16.oRdSop, 0);
    chk({tag, ".eop"},   if16.oRdEop, 0);
    chk({tag, ".last"},  if16.oRdLast, 0);
    chk({tag, ".keep"},  if16.oRdKeep, 0);
    chk({tag, ".data"},  if16.oRdData, 0);
    chk({tag, ".ready"}, if16.oRdReady, 1);
    chk({tag, ".err"},   err16, 0);
    chk({tag, ".code"},  code16, 0);
    chk({tag, ".pkt"},   pkt16, 0);
    chk({tag, ".errc"},  errc16, 0);
    chk({tag, ".vld32"}, if32.oRdVld, 0);
    chk({tag, ".pkt32"}, pkt32, 0);
  endtask

  task automatic pulse16(input bit sop);
    if (sop) if16.iRdSop = 1'b1;
    else     if16.iRdEop = 1'b1;
    @(posedge clk);
    #1;
    if16.iRdSop = 1'b0;
    if16.iRdEop = 1'b0;
  endtask

  task automatic send_beat16(input logic [31:0] d, input logic [3:0] k, input bit last);
    bit rdy;
    int n;
    n = 0;
    if16.iRdVld  = 1'b1;
    if16.iRdData = d;
    if16.iRdKeep = k;
    if16.iRdLast = last;
    do begin
      @(negedge clk);
      rdy = if16.oRdReady;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 300);
    chk("beat_accepted", rdy, 1);
    if16.iRdVld  = 1'b0;
    if16.iRdLast = 1'b0;
    if16.iRdData = '0;
    if16.iRdKeep = '0;
  endtask

  task automatic send_beat32(input logic [63:0] d, input logic [7:0] k, input bit last);
    bit rdy;
    int n;
    n = 0;
    if32.iRdVld  = 1'b1;
    if32.iRdData = d;
    if32.iRdKeep = k;
    if32.iRdLast = last;
    do begin
      @(negedge clk);
      rdy = if32.oRdReady;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 300);
    chk("beat32_accepted", rdy, 1);
    if32.iRdVld  = 1'b0;
    if32.iRdLast = 1'b0;
    if32.iRdData = '0;
    if32.iRdKeep = '0;
  endtask

  task automatic run_pkt(input string tag, input bit with_crc, input logic [15:0] crcv,
                         input bit extra_sop, input logic [1:0] code);
    int gbase, ebase, sbase, nb, n;
    logic [31:0] d;
    logic [3:0]  k;
    gbase = got16.size();
    ebase = ecode16.size();
    sbase = sop16;
    exp_beats.delete();
    nb = (pkt_bytes.size() + 3) / 4;
    pulse16(1'b1);
    for (int i = 0; i < nb; i++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4; j++) begin
        if (4*i + j < pkt_bytes.size()) begin
          d[8*j +: 8] = pkt_bytes[4*i + j];
          k[j] = 1'b1;
        end else if (garbage) begin
          d[8*j +: 8] = 8'($urandom);
        end
      end
      send_beat16(d, k, 1'b0);
      exp_beats.push_back({k, d});
      if (i == 0 && extra_sop) pulse16(1'b1);
    end
    if (with_crc) send_beat16({16'h0000, crcv}, 4'hF, 1'b1);
    pulse16(1'b0);
    n = 0;
    while (ecode16.size() == ebase && n < 400) begin
      @(negedge clk);
      n++;
    end
    exp_pkt++;
    if (code != 2'b00) exp_err++;
    chk({tag, ".eop_count"}, ecode16.size() - ebase, 1);
    chk({tag, ".sop_count"}, sop16 - sbase, 1);
    chk({tag, ".beat_count"}, got16.size() - gbase, exp_beats.size());
    for (int i = 0; i < exp_beats.size() && gbase + i < got16.size(); i++)
      chk($sformatf("%s.beat%0d", tag, i), got16[gbase + i], exp_beats[i]);
    if (ecode16.size() > ebase) begin
      chk({tag, ".code"}, ecode16[ebase], code);
      chk({tag, ".err"}, eerr16[ebase], code != 2'b00);
      chk({tag, ".eop_after_beats"}, enb16[ebase], gbase + exp_beats.size());
      chk({tag, ".pkt_cnt"}, epkt16[ebase], exp_pkt);
      chk({tag, ".err_cnt"}, eerrc16[ebase], exp_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_123456789();
    pkt_bytes.delete();
    for (int i = 0; i < 9; i++) pkt_bytes.push_back(8'h31 + 8'(i));
  endtask

  vec_t vecs[9];

  initial begin
    int gbase, ebase, n, nbytes;
    bit bad, nocrc, xs;
    logic [15:0] crcv;

    vecs[0] = '{"full8",    8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[1] = '{"tail1",    5,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[2] = '{"bad11",    11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[3] = '{"nocrc",    6,  1'b0, 1'b1, 1'b0, 1'b0, 2'b10};
    vecs[4] = '{"sopdata",  10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
    vecs[5] = '{"both",     7,  1'b1, 1'b0, 1'b1, 1'b0, 2'b11};
    vecs[6] = '{"bp64",     64, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[7] = '{"bp_bad",   23, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01};
    vecs[8] = '{"bp_nocrc", 13, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10};

    {if16.iRdSop, if16.iRdEop, if16.iRdVld, if16.iRdLast} = 4'b0;
    if16.iRdKeep = '0;
    if16.iRdData = '0;
    {if32.iRdSop, if32.iRdEop, if32.iRdVld, if32.iRdLast} = 4'b0;
    if32.iRdKeep = '0;
    if32.iRdData = '0;
    if32.iReady  = 1'b1;

    repeat (3) @(posedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    garbage = 0;
    load_123456789();
    run_pkt("tp_pass", 1'b1, 16'h29B1, 1'b0, 2'b00);
    run_pkt("tp_bad", 1'b1, 16'h29B2, 1'b0, 2'b01);

    garbage = 1;
    for (int v = 0; v < 9; v++) begin
      pkt_bytes.delete();
      for (int i = 0; i < vecs[v].nbytes; i++) pkt_bytes.push_back(8'($urandom));
      crcv = 16'(ref_crc(16, 32'h1021, 32'hFFFF, 32'h0)) ^ {15'b0, vecs[v].bad};
      bp_en = vecs[v].bp;
      run_pkt(vecs[v].name, !vecs[v].no_crc, crcv, vecs[v].extra_sop, vecs[v].exp_code);
      bp_en = 0;
    end

    for (int r = 0; r < 10; r++) begin
      nbytes = $urandom_range(1, 40);
      bad    = 1'($urandom_range(0, 1));
      nocrc  = ($urandom_range(0, 5) == 0);
      xs     = ($urandom_range(0, 5) == 0);
      pkt_bytes.delete();
      for (int i = 0; i < nbytes; i++) pkt_bytes.push_back(8'($urandom));
      crcv = 16'(ref_crc(16, 32'h1021, 32'hFFFF, 32'h0)) ^ {15'b0, bad};
      bp_en = 1'($urandom_range(0, 1));
      run_pkt($sformatf("rand%0d", r), !nocrc, crcv, xs, {nocrc | xs, bad & !nocrc});
      bp_en = 0;
    end

    gbase = got16.size();
    ebase = ecode16.size();
    send_beat16($urandom, 4'hF, 1'b0);
    repeat (4) @(negedge clk);
    exp_err++;
    chk("orphan.no_beat", got16.size() - gbase, 0);
    chk("orphan.no_eop", ecode16.size() - ebase, 0);
    chk("orphan.err_cnt", errc16, exp_err);
    chk("orphan.pkt_cnt", pkt16, exp_pkt);
    @(posedge clk);
    #1;

    gbase = got32.size();
    ebase = ecode32.size();
    if32.iRdSop = 1'b1;
    @(posedge clk);
    #1;
    if32.iRdSop = 1'b0;
    send_beat32(64'h3837363534333231, 8'hFF, 1'b0);
    send_beat32(64'h0000000000000039, 8'h01, 1'b0);
    send_beat32(64'h00000000FC891918, 8'hFF, 1'b1);
    if32.iRdEop = 1'b1;
    @(posedge clk);
    #1;
    if32.iRdEop = 1'b0;
    n = 0;
    while (ecode32.size() == ebase && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("crc32.beat_count", got32.size() - gbase, 3);
    chk("crc32.eop_count", ecode32.size() - ebase, 1);
    if (got32.size() - gbase == 3) begin
      chk("crc32.b0", got32[gbase],     {1'b0, 8'hFF, 64'h3837363534333231});
      chk("crc32.b1", got32[gbase + 1], {1'b0, 8'h01, 64'h0000000000000039});
      chk("crc32.b2_last", got32[gbase + 2][72], 1);
      chk("crc32.b2_data", got32[gbase + 2][63:0], 64'h00000000FC891918);
    end
    if (ecode32.size() > ebase) begin
      chk("crc32.err", eerr32[ebase], 0);
      chk("crc32.code", ecode32[ebase], 2'b00);
    end
    @(posedge clk);
    #1;

    pulse16(1'b1);
    send_beat16(32'h11223344, 4'hF, 1'b0);
    send_beat16(32'h55667788, 4'hF, 1'b0);
    rst_n = 1'b0;
    check_reset("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pkt = 0;
    exp_err = 0;
    @(posedge clk);
    #1;
    garbage = 0;
    load_123456789();
    run_pkt("after_rst", 1'b1, 16'h29B1, 1'b0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
